mem_arbiter: RTL

//   Shares the single-port program RAM between three requesters: bootloader (write-only),
//   CPU (read/write) and UART debug memory-dump (read-only). Sits between the bootloader,
//   CPU and RAM. booting gates eligibility so only the bootloader touches RAM during a load.

---
 rtl/mem_arbiter_pkg.sv | 25 ++
 rtl/arb_rr2.sv | 15 +
 rtl/mem_arbiter.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the program-RAM arbiter: address width,
// FSM state codes and requester IDs.
package mem_arbiter_pkg;

  localparam int RAM_ADDR_BITS = 16;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    CPU  = 2'd1,
    DBG  = 2'd2
  } req_id_t;

  function automatic logic [15:0] sat_inc(
    input logic [15:0] v
  );
    return (&v) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin picker; bit 0 = cpu, bit 1 = dbg.
// last = 1 means bit 1 won most recently.
module arb_rr2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  always_comb begin
    grant = req;
    if (req == 2'b11)
      grant = last ? 2'b01 : 2'b10;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Three-way program-RAM arbiter (boot / cpu / dbg), 3 cycles per access.
// Define MEM_ARB_STATS_EN to add saturating wait-cycle counters.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int AW = RAM_ADDR_BITS,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          booting,
  input  logic          boot_req,
  input  logic [AW-1:0] boot_addr,
  input  logic [DW-1:0] boot_wdata,
  output logic          boot_ack,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  input  logic          dbg_req,
  input  logic [AW-1:0] dbg_addr,
  output logic          dbg_ack,
  output logic [DW-1:0] rd_data,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_q
`ifdef MEM_ARB_STATS_EN
  ,
  input  logic          stat_clr,
  output logic [15:0]   stat_cpu_wait,
  output logic [15:0]   stat_dbg_wait
`endif
);

  state_t        r_state;
  state_t        w_next;
  req_id_t       r_win;
  req_id_t       w_win;
  logic          r_we;
  logic          r_last;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [DW-1:0] r_rd;
  logic          w_grant;
  logic          w_we;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_wdata;
  logic [1:0]    w_rr_gnt;
  logic          w_done;

  arb_rr2 u_rr (
    .req   ({dbg_req, cpu_req}),
    .last  (r_last),
    .grant (w_rr_gnt)
  );

  always_comb begin
    w_next  = r_state;
    w_grant = 1'b0;
    w_win   = r_win;
    w_we    = 1'b0;
    w_addr  = r_addr;
    w_wdata = r_wdata;
    unique case (r_state)
      S_IDLE: begin
        unique case (1'b1)
          booting & boot_req: begin
            w_grant = 1'b1;
            w_win   = BOOT;
            w_we    = 1'b1;
            w_addr  = boot_addr;
            w_wdata = boot_wdata;
          end
          !booting & w_rr_gnt[0]: begin
            w_grant = 1'b1;
            w_win   = CPU;
            w_we    = cpu_we;
            w_addr  = cpu_addr;
            w_wdata = cpu_wdata;
          end
          !booting & w_rr_gnt[1]: begin
            w_grant = 1'b1;
            w_win   = DBG;
            w_addr  = dbg_addr;
            w_wdata = '0;
          end
          default: ;
        endcase
        if (w_grant)
          w_next = S_ACCESS;
      end
      S_ACCESS: w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_win   <= BOOT;
      r_we    <= 1'b0;
      r_last  <= 1'b1;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rd    <= '0;
    end else begin
      r_state <= w_next;
      if (w_grant) begin
        r_win   <= w_win;
        r_we    <= w_we;
        r_addr  <= w_addr;
        r_wdata <= w_wdata;
        if (w_win != BOOT)
          r_last <= (w_win == DBG);
      end
      if (w_done && !r_we)
        r_rd <= ram_q;
    end
  end

  // Strobes decode from state so an async reset drops them at once.
  assign w_done    = (r_state == S_DONE);
  assign ram_en    = (r_state == S_ACCESS);
  assign ram_we    = ram_en & r_we;
  assign ram_addr  = r_addr;
  assign ram_wdata = r_wdata;
  assign boot_ack  = w_done & (r_win == BOOT);
  assign cpu_ack   = w_done & (r_win == CPU);
  assign dbg_ack   = w_done & (r_win == DBG);
  assign rd_data   = (w_done & ~r_we) ? ram_q : r_rd;

`ifdef MEM_ARB_STATS_EN
  logic [15:0] r_cpu_wait;
  logic [15:0] r_dbg_wait;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cpu_wait <= '0;
      r_dbg_wait <= '0;
    end else if (stat_clr) begin
      r_cpu_wait <= '0;
      r_dbg_wait <= '0;
    end else begin
      if (cpu_req && !cpu_ack)
        r_cpu_wait <= sat_inc(r_cpu_wait);
      if (dbg_req && !dbg_ack)
        r_dbg_wait <= sat_inc(r_dbg_wait);
    end
  end

  assign stat_cpu_wait = r_cpu_wait;
  assign stat_dbg_wait = r_dbg_wait;
`endif

endmodule
